// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared fetch state, buffer entry and encodings
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] EBREAK = 32'h00100073;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer of {pc, instr} entries with flush
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-outstanding instruction fetch unit; INST_FETCH_ALIGN_CHK_EN adds fault
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef INST_FETCH_ALIGN_CHK_EN
    ,
    output logic        fault
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e   state, state_n;
    logic [31:0]    fetch_pc, fetch_pc_n, tag_pc;
    logic           fault_q;
    logic           push, pop, full, empty;
    logic [CW-1:0]  count;
    fetch_entry_t   head;

`ifdef INST_FETCH_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else if (redirect && redirect_pc[1:0] != 2'b00)
            fault_q <= 1'b1;
    end
    assign fault = fault_q;
`else
    assign fault_q = 1'b0;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{pc: tag_pc, instr: mem_rsp_data}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign pop          = !empty && out_ready && !redirect;
    assign out_valid    = !empty;
    assign out_pc       = head.pc;
    assign out_instr    = empty ? EBREAK : head.instr;
    assign mem_req_addr = fetch_pc;

    // Issue only from IDLE, so the request's buffer slot is free when it is sent.
    always_comb begin
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        push          = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            IDLE: begin
                mem_req_valid = !rst && (count < CW'(DEPTH)) && !redirect && !fault_q;
                if (mem_req_valid && mem_req_ready) begin
                    fetch_pc_n = fetch_pc + 32'd4;
                    state_n    = WAIT;
                end
            end
            WAIT: begin
                if (redirect)
                    state_n = mem_rsp_valid ? IDLE : DROP;
                else if (mem_rsp_valid) begin
                    push    = !full;
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (mem_rsp_valid) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (redirect) fetch_pc_n = redirect_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            if (mem_req_valid && mem_req_ready) tag_pc <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and random checks of inst_fetch against a queue model
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h80000000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef INST_FETCH_ALIGN_CHK_EN
    logic        fault;
    logic        s_fault;
`endif

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef INST_FETCH_ALIGN_CHK_EN
        ,
        .fault         (fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] fpc = RESET_PC;
    logic [31:0] mtag = '0;
    bit          busy = 0;
    bit          discard = 0;
    bit          faulted = 0;

    int checks = 0;
    int errors = 0;

    logic        s_req, s_oval;
    logic [31:0] s_addr, s_opc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic ordy,
                        input logic rd, input logic [31:0] rpc);
        logic [31:0] d;
        bit exp_req, pop, hs, rsp;
        ent_t tmp;
        @(negedge clk);
        d = $urandom;
        rst = r; mem_req_ready = rdy; mem_rsp_valid = rv; mem_rsp_data = d;
        out_ready = ordy; redirect = rd; redirect_pc = rpc;
        #1;
        s_req = mem_req_valid; s_addr = mem_req_addr; s_oval = out_valid; s_opc = out_pc;
`ifdef INST_FETCH_ALIGN_CHK_EN
        s_fault = fault;
        chk("fault", 32'(fault), 32'(faulted));
`endif
        exp_req = !r && !busy && mq.size() < DEPTH && !rd && !faulted;
        chk("req_valid", 32'(mem_req_valid), 32'(exp_req));
        if (!r) chk("req_addr", mem_req_addr, fpc);
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
        end
        if (r) begin
            mq.delete(); fpc = RESET_PC; busy = 0; discard = 0; faulted = 0;
        end else begin
            pop = mq.size() != 0 && ordy && !rd;
            hs  = exp_req && rdy;
            rsp = busy && rv;
            if (pop) tmp = mq.pop_front();
            if (rsp && !discard && !rd) mq.push_back('{pc: mtag, instr: d});
            if (rd) begin
                mq.delete();
                fpc = rpc;
                if (rsp) begin busy = 0; discard = 0; end
                else if (busy) discard = 1;
`ifdef INST_FETCH_ALIGN_CHK_EN
                if (rpc[1:0] != 2'b00) faulted = 1;
`endif
            end else begin
                if (rsp) begin busy = 0; discard = 0; end
                if (hs) begin busy = 1; discard = 0; mtag = fpc; fpc = fpc + 32'd4; end
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 0, '0);
        step(1, 1, 0, 0, 0, '0);
    endtask

    initial begin
        int k, j, n;
        logic [31:0] hold;

        // Reset state
        do_reset();
        chk("reset_no_req", 32'(s_req), 32'd0);
        chk("reset_empty", 32'(s_oval), 32'd0);

        // Sequential fetch with a ready memory and 1-cycle latency
        k = 0; j = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, busy, 1, 0, '0);
            if (s_req) begin chk("seq_addr", s_addr, RESET_PC + 32'(4 * k)); k++; end
            if (s_oval) begin chk("seq_out_pc", s_opc, RESET_PC + 32'(4 * j)); j++; end
        end
        chk("seq_issued", 32'(k), 32'd6);

        // Redirect while waiting on 0x80000008: late response dropped
        do_reset();
        n = 0;
        while (!(busy && mtag == 32'h80000008) && n < 20) begin step(0, 1, busy, 1, 0, '0); n++; end
        chk("wait_on_8_reached", 32'(n < 20), 32'd1);
        step(0, 1, 0, 1, 1, 32'h80000100);
        step(0, 1, 1, 1, 0, '0);
        chk("drop_no_req", 32'(s_req), 32'd0);
        n = 0;
        do begin step(0, 1, busy, 0, 0, '0); n++; end while (!s_oval && n < 20);
        chk("redirect_out_pc", s_opc, 32'h80000100);

        // Redirect coinciding with a response
        n = 0;
        while (!busy && n < 10) begin step(0, 1, 0, 0, 0, '0); n++; end
        step(0, 1, 1, 0, 1, 32'h80000200);
        step(0, 1, 0, 0, 0, '0);
        chk("same_cycle_req", 32'(s_req), 32'd1);
        chk("same_cycle_addr", s_addr, 32'h80000200);
        chk("same_cycle_flushed", 32'(s_oval), 32'd0);

        // Request held while ready low
        n = 0;
        while (busy && n < 10) begin step(0, 0, 1, 1, 0, '0); n++; end
        hold = fpc;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, '0);
            chk("hold_valid", 32'(s_req), 32'd1);
            chk("hold_addr", s_addr, hold);
        end

        // Back-pressure fills the buffer; one pop allows one refill
        for (int i = 0; i < 10; i++) step(0, 1, busy, 0, 0, '0);
        chk("full_no_req", 32'(s_req), 32'd0);
        chk("full_valid", 32'(s_oval), 32'd1);
        step(0, 1, busy, 1, 0, '0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, busy, 0, 0, '0);
            if (s_req) n++;
        end
        chk("one_refill", 32'(n), 32'd1);

        // Reset mid-WAIT: late response ignored
        n = 0;
        while (!busy && n < 10) begin step(0, 1, busy, 1, 0, '0); n++; end
        step(1, 0, 0, 1, 0, '0);
        step(0, 0, 1, 1, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        chk("late_rsp_ignored", 32'(s_oval), 32'd0);

`ifdef INST_FETCH_ALIGN_CHK_EN
        do_reset();
        step(0, 1, 0, 1, 1, 32'h80000102);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, busy, 1, 0, '0);
            chk("fault_set", 32'(s_fault), 32'd1);
            chk("fault_blocks", 32'(s_req), 32'd0);
        end
        do_reset();
        step(0, 1, 0, 1, 0, '0);
        chk("fault_cleared", 32'(s_fault), 32'd0);
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 busy ? ($urandom_range(0, 2) != 0) : 1'b0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom & 32'hFFFF_FFFC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
